// File: rtl/dsi_reset_seq_if.sv
// Control/status bundle between the DSI reset sequencer and the rest of the transmitter.
// master: the sequencer itself; slave: PLL/init-sequencer side that observes the resets.
interface dsi_reset_seq_if;
    logic       pll_lock;
    logic       init_done;
    logic       phy_rst;
    logic       panel_rst_n;
    logic       init_start;
    logic       video_rst;
    logic       ready;
    logic       err;
    logic [2:0] state;

    modport master (
        input  pll_lock,
        input  init_done,
        output phy_rst,
        output panel_rst_n,
        output init_start,
        output video_rst,
        output ready,
        output err,
        output state
    );

    modport slave (
        output pll_lock,
        output init_done,
        input  phy_rst,
        input  panel_rst_n,
        input  init_start,
        input  video_rst,
        input  ready,
        input  err,
        input  state
    );
endinterface

// File: rtl/dsi_reset_seq.sv
// DSI power-up sequencer: PLL lock -> PHY release -> panel reset pulse -> panel init -> video.
// Lock loss restarts from WAIT_LOCK; an init timeout retries from the panel reset.
module dsi_reset_seq #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned T_SETTLE     = 255,
    parameter int unsigned T_PANEL_RST  = 1000,
    parameter int unsigned T_PANEL_WAIT = 5000,
    parameter int unsigned T_INIT_TO    = 50000
) (
    input  logic          clk,
    input  logic          rst,
    dsi_reset_seq_if.master bus
);

    localparam logic [2:0] StWaitLock  = 3'd0;
    localparam logic [2:0] StSettle    = 3'd1;
    localparam logic [2:0] StPanelRst  = 3'd2;
    localparam logic [2:0] StPanelWait = 3'd3;
    localparam logic [2:0] StInit      = 3'd4;
    localparam logic [2:0] StRun       = 3'd5;

    // A timed state exits on the edge where cnt == T-1.
    localparam logic [CNT_W-1:0] SettleLast    = CNT_W'(T_SETTLE - 1);
    localparam logic [CNT_W-1:0] PanelRstLast  = CNT_W'(T_PANEL_RST - 1);
    localparam logic [CNT_W-1:0] PanelWaitLast = CNT_W'(T_PANEL_WAIT - 1);
    localparam logic [CNT_W-1:0] InitToLast    = CNT_W'(T_INIT_TO - 1);

    logic             sync1_q, lock_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phy_rst_q, phy_rst_d;
    logic             panel_rst_n_q, panel_rst_n_d;
    logic             init_start_q, init_start_d;
    logic             video_rst_q, video_rst_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (state_q != StWaitLock && !lock_s_q) begin
            state_d = StWaitLock;
        end else begin
            case (state_q)
                StWaitLock:  if (lock_s_q) state_d = StSettle;
                StSettle:    if (cnt_q == SettleLast) state_d = StPanelRst;
                StPanelRst:  if (cnt_q == PanelRstLast) state_d = StPanelWait;
                StPanelWait: if (cnt_q == PanelWaitLast) state_d = StInit;
                StInit: begin
                    if (bus.init_done) begin
                        state_d = StRun;
                    end else if (cnt_q == InitToLast) begin
                        state_d = StPanelRst;
                        err_d   = 1'b1;
                    end
                end
                StRun:       state_d = StRun;
                default:     state_d = StWaitLock;
            endcase
        end
    end

    // Untimed states hold the counter at zero so it never wraps.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q || state_q == StWaitLock || state_q == StRun) begin
            cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they switch with the state register.
    always_comb begin
        phy_rst_d     = (state_d == StWaitLock) || (state_d == StSettle);
        panel_rst_n_d = (state_d == StPanelWait) || (state_d == StInit) || (state_d == StRun);
        video_rst_d   = (state_d != StRun);
        ready_d       = (state_d == StRun);
        init_start_d  = (state_d == StInit) && (state_q != StInit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= 1'b0;
            lock_s_q      <= 1'b0;
            state_q       <= StWaitLock;
            cnt_q         <= '0;
            phy_rst_q     <= 1'b1;
            panel_rst_n_q <= 1'b0;
            init_start_q  <= 1'b0;
            video_rst_q   <= 1'b1;
            ready_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            sync1_q       <= bus.pll_lock;
            lock_s_q      <= sync1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phy_rst_q     <= phy_rst_d;
            panel_rst_n_q <= panel_rst_n_d;
            init_start_q  <= init_start_d;
            video_rst_q   <= video_rst_d;
            ready_q       <= ready_d;
            err_q         <= err_d;
        end
    end

    assign bus.phy_rst     = phy_rst_q;
    assign bus.panel_rst_n = panel_rst_n_q;
    assign bus.init_start  = init_start_q;
    assign bus.video_rst   = video_rst_q;
    assign bus.ready       = ready_q;
    assign bus.err         = err_q;
    assign bus.state       = state_q;

endmodule
